// File: rtl/uart_line_echo.sv
// uart_line_echo: character or line echo between a FIFO-style UART and the board.
// In line mode, received bytes are buffered with backspace editing. The line is
// sent back, followed by CR LF, when CR arrives or the buffer fills.
// Optional feature macro: UART_ECHO_UPCASE_EN folds a-z to A-Z on transmit.
module uart_line_echo #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LINE_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] CR_CODE    = DATA_WIDTH'(8'h0D),
  parameter logic [DATA_WIDTH-1:0] LF_CODE    = DATA_WIDTH'(8'h0A),
  parameter logic [DATA_WIDTH-1:0] BS_CODE    = DATA_WIDTH'(8'h08)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          line_mode,
  input  logic                          rx_data_present,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          read_from_uart,
  input  logic                          tx_full,
  output logic                          write_to_uart,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [$clog2(LINE_DEPTH):0]   line_count,
  output logic                          busy,
  output logic                          overflow,
  output logic [DATA_WIDTH-1:0]         last_tx
);

  localparam int AW = $clog2(LINE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PROC, S_ECHO, S_SEND, S_CR, S_LF
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rx_hold_q, rx_hold_d;
  logic [CW-1:0]         line_count_q, line_count_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] last_tx_q, last_tx_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  buf_we;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_byte;
  logic [CW-1:0]         store_cnt;
  logic [DATA_WIDTH-1:0] line_buf_q [LINE_DEPTH];

`ifdef UART_ECHO_UPCASE_EN
  // Lower-case ASCII letters lose bit 5 on their way to the TX register.
  function automatic logic [DATA_WIDTH-1:0] tx_xform(input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = b;
    if (b >= DATA_WIDTH'(8'h61) && b <= DATA_WIDTH'(8'h7A)) r[5] = 1'b0;
    return r;
  endfunction
`else
  // Bytes go out unmodified.
  function automatic logic [DATA_WIDTH-1:0] tx_xform(input logic [DATA_WIDTH-1:0] b);
    return b;
  endfunction
`endif

  // Next-state and output decode; every push goes through one shared path.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    rx_hold_d    = rx_hold_q;
    line_count_d = line_count_q;
    idx_d        = idx_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    tx_data_d    = tx_data_q;
    last_tx_d    = last_tx_q;
    ovf_d        = 1'b0;
    buf_we       = 1'b0;
    push         = 1'b0;
    push_byte    = '0;
    store_cnt    = line_count_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (rx_data_present) begin
          rd_d      = 1'b1;
          rx_hold_d = rx_data;
          mode_d    = line_mode;
          state_d   = S_PROC;
        end
      end
      S_PROC: begin
        if (!mode_q) begin
          state_d = S_ECHO;
        end else if (rx_hold_q == CR_CODE) begin
          state_d = (line_count_q != '0) ? S_SEND : S_CR;
        end else if (rx_hold_q == BS_CODE) begin
          if (line_count_q != '0) line_count_d = line_count_q - CW'(1);
          state_d = S_IDLE;
        end else begin
          buf_we       = 1'b1;
          line_count_d = store_cnt;
          if (store_cnt == CW'(LINE_DEPTH)) begin
            ovf_d   = 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ECHO: begin
        if (!tx_full) begin
          push      = 1'b1;
          push_byte = rx_hold_q;
          state_d   = S_IDLE;
        end
      end
      S_SEND: begin
        if (!tx_full) begin
          push      = 1'b1;
          push_byte = line_buf_q[idx_q];
          idx_d     = idx_q + AW'(1);
          if ({1'b0, idx_q} == line_count_q - CW'(1)) state_d = S_CR;
        end
      end
      S_CR: begin
        if (!tx_full) begin
          push      = 1'b1;
          push_byte = CR_CODE;
          state_d   = S_LF;
        end
      end
      S_LF: begin
        if (!tx_full) begin
          push         = 1'b1;
          push_byte    = LF_CODE;
          line_count_d = '0;
          idx_d        = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) begin
      wr_d      = 1'b1;
      tx_data_d = tx_xform(push_byte);
      last_tx_d = tx_xform(push_byte);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears control and visible outputs.
  always_ff @(posedge clock) begin
    rx_hold_q <= rx_hold_d;
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      line_count_q <= '0;
      idx_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      tx_data_q    <= '0;
      last_tx_q    <= '0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      line_count_q <= line_count_d;
      idx_q        <= idx_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      tx_data_q    <= tx_data_d;
      last_tx_q    <= last_tx_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  // Line buffer storage; contents are meaningless beyond line_count.
  always_ff @(posedge clock) begin
    if (buf_we && !reset) line_buf_q[line_count_q[AW-1:0]] <= rx_hold_q;
  end

  assign read_from_uart = rd_q;
  assign write_to_uart  = wr_q;
  assign tx_data        = tx_data_q;
  assign line_count     = line_count_q;
  assign busy           = busy_q;
  assign overflow       = ovf_q;
  assign last_tx        = last_tx_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo with a 4-entry line buffer.
module tb_uart_line_echo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       line_mode = 1'b0;
  logic       rx_data_present = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       read_from_uart;
  logic       tx_full = 1'b0;
  logic       write_to_uart;
  logic [7:0] tx_data;
  logic [2:0] line_count;
  logic       busy;
  logic       overflow;
  logic [7:0] last_tx;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic full_at_edge = 1'b0;
  int pops = 0;
  int ovf_cnt = 0;
  int bp_viol = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int tx_cycq[$];
  int pop_cycq[$];

  uart_line_echo #(.LINE_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .line_mode(line_mode),
    .rx_data_present(rx_data_present), .rx_data(rx_data),
    .read_from_uart(read_from_uart), .tx_full(tx_full),
    .write_to_uart(write_to_uart), .tx_data(tx_data),
    .line_count(line_count), .busy(busy), .overflow(overflow),
    .last_tx(last_tx)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    full_at_edge <= tx_full;
  end

  // RX FIFO model and TX capture, on the falling edge.
  always @(negedge clock) begin
    if (read_from_uart === 1'b1) begin
      pops++;
      pop_cycq.push_back(cyc);
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (write_to_uart === 1'b1) begin
      txq.push_back(tx_data);
      tx_cycq.push_back(cyc);
      if (full_at_edge) bp_viol++;
    end
    if (overflow === 1'b1) ovf_cnt++;
    rx_data_present = (rxq.size() != 0);
    rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  function automatic logic [7:0] ex(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b & 8'hDF;
`endif
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    txq.delete();
    tx_cycq.delete();
    pop_cycq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    nvec++; if (read_from_uart !== 1'b0) begin nerr++; $display("FAIL rst_read got %b want 0", read_from_uart); end
    nvec++; if (write_to_uart !== 1'b0) begin nerr++; $display("FAIL rst_write got %b want 0", write_to_uart); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    nvec++; if (line_count !== 3'd0) begin nerr++; $display("FAIL rst_line_count got %0d want 0", line_count); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_overflow got %b want 0", overflow); end
    nvec++; if (last_tx !== 8'h00) begin nerr++; $display("FAIL rst_last_tx got %h want 00", last_tx); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_char_echo();
    int k, p0;
    clear_logs();
    line_mode = 1'b0;
    p0 = pops;
    k = cyc;
    rxq.push_back(8'h41);
    for (int i = 0; i < 20 && txq.size() < 1; i++) tick(1);
    tick(3);
    nvec++; if (txq.size() !== 1) begin nerr++; $display("FAIL char_count got %0d want 1", txq.size()); end
    if (txq.size() >= 1) begin
      nvec++; if (txq[0] !== 8'h41) begin nerr++; $display("FAIL char_data got %h want 41", txq[0]); end
      nvec++; if (tx_cycq[0] !== k + 3) begin nerr++; $display("FAIL char_write_lat got %0d want %0d", tx_cycq[0] - k, 3); end
    end
    nvec++; if (pops - p0 !== 1) begin nerr++; $display("FAIL char_pops got %0d want 1", pops - p0); end
    if (pop_cycq.size() >= 1) begin
      nvec++; if (pop_cycq[0] !== k + 1) begin nerr++; $display("FAIL char_read_lat got %0d want 1", pop_cycq[0] - k); end
    end
    nvec++; if (last_tx !== 8'h41) begin nerr++; $display("FAIL char_last_tx got %h want 41", last_tx); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL char_busy got %b want 0", busy); end
  endtask

  task automatic test_line_basic();
    logic [7:0] exp [5];
    clear_logs();
    line_mode = 1'b1;
    rxq.push_back(8'h61); rxq.push_back(8'h62); rxq.push_back(8'h63);
    tick(15);
    nvec++; if (txq.size() !== 0) begin nerr++; $display("FAIL line_early_tx got %0d want 0", txq.size()); end
    nvec++; if (line_count !== 3'd3) begin nerr++; $display("FAIL line_count3 got %0d want 3", line_count); end
    rxq.push_back(8'h0D);
    for (int i = 0; i < 30 && txq.size() < 5; i++) tick(1);
    tick(2);
    exp[0] = ex(8'h61); exp[1] = ex(8'h62); exp[2] = ex(8'h63); exp[3] = 8'h0D; exp[4] = 8'h0A;
    nvec++; if (txq.size() !== 5) begin nerr++; $display("FAIL line_len got %0d want 5", txq.size()); end
    for (int i = 0; i < 5 && i < txq.size(); i++) begin
      nvec++; if (txq[i] !== exp[i]) begin nerr++; $display("FAIL line_byte%0d got %h want %h", i, txq[i], exp[i]); end
      nvec++; if (tx_cycq[i] !== tx_cycq[0] + i) begin nerr++; $display("FAIL line_gap%0d got %0d want %0d", i, tx_cycq[i] - tx_cycq[0], i); end
    end
    nvec++; if (line_count !== 3'd0) begin nerr++; $display("FAIL line_count0 got %0d want 0", line_count); end
  endtask

  task automatic test_backspace();
    logic [7:0] exp [4];
    clear_logs();
    line_mode = 1'b1;
    rxq.push_back(8'h08);
    tick(10);
    nvec++; if (line_count !== 3'd0) begin nerr++; $display("FAIL bs_empty_count got %0d want 0", line_count); end
    nvec++; if (txq.size() !== 0) begin nerr++; $display("FAIL bs_empty_tx got %0d want 0", txq.size()); end
    rxq.push_back(8'h61); rxq.push_back(8'h62); rxq.push_back(8'h08);
    rxq.push_back(8'h63); rxq.push_back(8'h0D);
    for (int i = 0; i < 40 && txq.size() < 4; i++) tick(1);
    tick(3);
    exp[0] = ex(8'h61); exp[1] = ex(8'h63); exp[2] = 8'h0D; exp[3] = 8'h0A;
    nvec++; if (txq.size() !== 4) begin nerr++; $display("FAIL bs_len got %0d want 4", txq.size()); end
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      nvec++; if (txq[i] !== exp[i]) begin nerr++; $display("FAIL bs_byte%0d got %h want %h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [6];
    int o0;
    clear_logs();
    line_mode = 1'b1;
    o0 = ovf_cnt;
    rxq.push_back(8'h77); rxq.push_back(8'h78); rxq.push_back(8'h79); rxq.push_back(8'h7A);
    rxq.push_back(8'h71);
    for (int i = 0; i < 40 && txq.size() < 6; i++) tick(1);
    tick(6);
    exp[0] = ex(8'h77); exp[1] = ex(8'h78); exp[2] = ex(8'h79); exp[3] = ex(8'h7A);
    exp[4] = 8'h0D; exp[5] = 8'h0A;
    nvec++; if (ovf_cnt - o0 !== 1) begin nerr++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - o0); end
    nvec++; if (txq.size() !== 6) begin nerr++; $display("FAIL ovf_len got %0d want 6", txq.size()); end
    for (int i = 0; i < 6 && i < txq.size(); i++) begin
      nvec++; if (txq[i] !== exp[i]) begin nerr++; $display("FAIL ovf_byte%0d got %h want %h", i, txq[i], exp[i]); end
    end
    if (pop_cycq.size() >= 5 && tx_cycq.size() >= 6) begin
      nvec++; if (pop_cycq[4] <= tx_cycq[5]) begin nerr++; $display("FAIL ovf_pop_during_flush got %0d want >%0d", pop_cycq[4], tx_cycq[5]); end
    end
    nvec++; if (line_count !== 3'd1) begin nerr++; $display("FAIL ovf_after_count got %0d want 1", line_count); end
    rxq.push_back(8'h08);
    tick(8);
    nvec++; if (line_count !== 3'd0) begin nerr++; $display("FAIL ovf_bs_count got %0d want 0", line_count); end
  endtask

  task automatic test_back_pressure();
    int p0;
    clear_logs();
    line_mode = 1'b0;
    tx_full = 1'b1;
    p0 = pops;
    rxq.push_back(8'h55); rxq.push_back(8'h66);
    tick(2);
    tick(10);
    nvec++; if (txq.size() !== 0) begin nerr++; $display("FAIL bp_write_while_full got %0d want 0", txq.size()); end
    nvec++; if (pops - p0 !== 1) begin nerr++; $display("FAIL bp_pops_stall got %0d want 1", pops - p0); end
    tx_full = 1'b0;
    for (int i = 0; i < 30 && txq.size() < 2; i++) tick(1);
    tick(3);
    nvec++; if (txq.size() !== 2) begin nerr++; $display("FAIL bp_len got %0d want 2", txq.size()); end
    if (txq.size() >= 2) begin
      nvec++; if (txq[0] !== 8'h55) begin nerr++; $display("FAIL bp_byte0 got %h want 55", txq[0]); end
      nvec++; if (txq[1] !== 8'h66) begin nerr++; $display("FAIL bp_byte1 got %h want 66", txq[1]); end
    end
    nvec++; if (bp_viol !== 0) begin nerr++; $display("FAIL bp_violation got %0d want 0", bp_viol); end
  endtask

  task automatic test_reset_mid_send();
    clear_logs();
    line_mode = 1'b1;
    tx_full = 1'b1;
    rxq.push_back(8'h61); rxq.push_back(8'h62); rxq.push_back(8'h0D);
    tick(15);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rms_busy_before got %b want 1", busy); end
    nvec++; if (line_count !== 3'd2) begin nerr++; $display("FAIL rms_count_before got %0d want 2", line_count); end
    reset = 1'b1;
    tick(1);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rms_busy got %b want 0", busy); end
    nvec++; if (line_count !== 3'd0) begin nerr++; $display("FAIL rms_count got %0d want 0", line_count); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL rms_tx_data got %h want 00", tx_data); end
    nvec++; if (last_tx !== 8'h00) begin nerr++; $display("FAIL rms_last_tx got %h want 00", last_tx); end
    nvec++; if (write_to_uart !== 1'b0 || read_from_uart !== 1'b0 || overflow !== 1'b0) begin
      nerr++; $display("FAIL rms_pulses got %b%b%b want 000", write_to_uart, read_from_uart, overflow);
    end
    tx_full = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(10);
    nvec++; if (txq.size() !== 0) begin nerr++; $display("FAIL rms_no_writes got %0d want 0", txq.size()); end
    rxq.push_back(8'h0D);
    for (int i = 0; i < 20 && txq.size() < 2; i++) tick(1);
    tick(3);
    nvec++; if (txq.size() !== 2) begin nerr++; $display("FAIL rms_cr_len got %0d want 2", txq.size()); end
    if (txq.size() >= 2) begin
      nvec++; if (txq[0] !== 8'h0D || txq[1] !== 8'h0A) begin nerr++; $display("FAIL rms_cr_bytes got %h %h want 0d 0a", txq[0], txq[1]); end
    end
  endtask

  task automatic test_upcase();
    logic [7:0] want;
`ifdef UART_ECHO_UPCASE_EN
    want = 8'h51;
`else
    want = 8'h71;
`endif
    clear_logs();
    line_mode = 1'b0;
    rxq.push_back(8'h71);
    for (int i = 0; i < 20 && txq.size() < 1; i++) tick(1);
    tick(2);
    nvec++; if (txq.size() !== 1) begin nerr++; $display("FAIL up_len got %0d want 1", txq.size()); end
    if (txq.size() >= 1) begin
      nvec++; if (txq[0] !== want) begin nerr++; $display("FAIL up_tx_data got %h want %h", txq[0], want); end
    end
    nvec++; if (last_tx !== want) begin nerr++; $display("FAIL up_last_tx got %h want %h", last_tx, want); end
  endtask

  initial begin
    test_reset();
    test_char_echo();
    test_line_basic();
    test_backspace();
    test_overflow();
    test_back_pressure();
    test_reset_mid_send();
    test_upcase();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
